seven_seg_to_bcd: RTL and testbench
===================================

# seven_seg_to_bcd

Registered decoder for the return path of the segment display interface: samples a time-multiplexed, active-high 7-segment bus (one-hot digit enable plus segment lines), filters each digit for stability, converts valid patterns back to BCD, and assembles a full multi-digit BCD word with a one-cycle valid strobe. It sits on the observation/loopback side of the display driver and is the inverse of the team's BCD-to-7-segment encoding table.

## Interface

- NUM_DIGITS, 4, number of multiplexed digits (1–8); digit 0 is the least-significant nibble
- STABLE_CYCLES, 3, consecutive identical samples required to accept a digit (2–15)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- seg_in  input  7  segment lines, bit0=A, bit1=B, … bit6=G, 1 = lit
- digit_en  input  NUM_DIGITS  one-hot digit select; all-zero = blanking interval
- bcd_value  output  4*NUM_DIGITS  last completed frame; nibble i = digit i
- bcd_valid  output  1  one-cycle pulse when bcd_value is updated
- frame_error  output  1  set with bcd_valid when the frame contained an invalid pattern; held until next frame
- digit_err  output  NUM_DIGITS  per-digit invalid flags for the completed frame, updated with bcd_valid

## Operation

- Valid patterns (seg_in hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67. Any other pattern (including 00, 6F, 27) decodes to nibble F and sets that digit's error flag.
- Sample register holds previous {seg_in, digit_en}; stability counter cnt (saturating at STABLE_CYCLES).
- Each edge: if digit_en is not exactly one-hot → cnt=0 (no accept). Else if inputs equal sample register → cnt=min(cnt+1, STABLE_CYCLES). Else → cnt=1. Sample register always loads current inputs.
- Accept: on the edge where cnt becomes STABLE_CYCLES (transition only, never again while held). Decoded nibble and error flag written to slot of selected digit; slot's seen bit set.
- Re-accept of an already-seen digit before frame completion overwrites its slot and flag.
- Frame complete: accept that makes seen all-ones. On that same edge: bcd_value ← all slots (including new nibble), digit_err ← all flags, frame_error ← OR of flags, bcd_valid ← 1, seen cleared.
- Digits may arrive in any order; no timeout; a partial frame is held indefinitely.

## Timing

- Reset values: bcd_value=0, bcd_valid=0, frame_error=0, digit_err=0; seen, slots, flags, cnt, sample register cleared.
- Reset mid-frame discards partial frame; first accept after reset requires STABLE_CYCLES fresh samples.
- Acceptance latency: inputs stable and one-hot at edges e1..eS (S=STABLE_CYCLES) → slot written at eS.
- Completing digit accepted at eS → bcd_value/digit_err/frame_error change at eS, bcd_valid high for exactly the cycle following eS, low at eS+1.
- Back-to-back frames: bcd_valid never high two consecutive cycles (minimum S edges per accept).
- Held digit for N > S cycles produces exactly one accept. A change of seg_in or digit_en, or a blanking cycle, rearms acceptance.
- Reset asserted in the same cycle as a completing accept wins: outputs reset, no bcd_valid.

## Test plan

- Defaults; digit_en 0001/seg 06, 0010/5B, 0100/4F, 1000/66, 3 cycles each → single bcd_valid pulse 3 cycles after last digit first sampled, bcd_value=16'h4321, frame_error=0, digit_err=0.
- Same scan but digit 1 held only 2 cycles, then digit 1 held 3 cycles with 7D → no premature pulse; bcd_value=16'h4361.
- Digit 2 driven 49 (invalid), others valid 0,1,3 → bcd_value=16'h3F10, digit_err=0100, frame_error=1; next clean frame clears both.
- digit_en=0011 and 0000 held 10 cycles with seg 7F → no accepts, no bcd_valid; digit 0 held 20 cycles → exactly one accept.
- Reset pulsed after digits 0–2 accepted, then only digit 3 driven → no bcd_valid; outputs remain reset values until all four digits reaccepted.
- Digits scanned 3,1,0,2 with 67,07,3F,08 → bcd_value=16'h9F70 with digit_err=0100... corrected: digit 2 pattern 08 invalid → nibble F, bcd_value=16'h9F70, frame_error=1.

Source files
------------

// File: rtl/seven_seg_to_bcd.sv
// rtl/seven_seg_to_bcd.sv - decodes a multiplexed 7-segment bus back into a BCD word
// Each digit must be stable for STABLE_CYCLES samples before it is accepted into the frame.
module seven_seg_to_bcd #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] bcd_value,
  output logic                    bcd_valid,
  output logic                    frame_error,
  output logic [NUM_DIGITS-1:0]   digit_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic [4*NUM_DIGITS-1:0] slots;
  logic [4*NUM_DIGITS-1:0] slots_next;
  logic [NUM_DIGITS-1:0]   flags;
  logic [NUM_DIGITS-1:0]   flags_next;
  logic [NUM_DIGITS-1:0]   seen;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    one_hot;
  logic                    accept;
  logic                    complete;
  logic [3:0]              nib;
  logic                    bad;

  always_comb begin
    nib = 4'hF;
    bad = 1'b0;
    case (seg_in)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h67: nib = 4'h9;
      default: begin
        nib = 4'hF;
        bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    one_hot = (digit_en != '0) && ((digit_en & (digit_en - 1'b1)) == '0);
    cnt_next = '0;
    if (one_hot) begin
      if (seg_in == seg_q && digit_en == en_q)
        cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
      else
        cnt_next = CW'(1);
    end
    // Accept only on the transition into saturation so a held digit counts once.
    accept = one_hot && (cnt_next == CNT_MAX) && (cnt != CNT_MAX);

    slots_next = slots;
    flags_next = flags;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_en[i]) begin
        slots_next[4*i +: 4] = nib;
        flags_next[i]        = bad;
      end
    end
    seen_next = seen | digit_en;
    complete  = accept && (&seen_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q       <= '0;
      en_q        <= '0;
      cnt         <= '0;
      slots       <= '0;
      flags       <= '0;
      seen        <= '0;
      bcd_value   <= '0;
      bcd_valid   <= 1'b0;
      frame_error <= 1'b0;
      digit_err   <= '0;
    end else begin
      seg_q     <= seg_in;
      en_q      <= digit_en;
      cnt       <= cnt_next;
      bcd_valid <= complete;
      if (accept) begin
        slots <= slots_next;
        flags <= flags_next;
        if (complete) begin
          bcd_value   <= slots_next;
          digit_err   <= flags_next;
          frame_error <= |flags_next;
          seen        <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_to_bcd.sv
// tb/tb_seven_seg_to_bcd.sv - scoreboard bench for seven_seg_to_bcd
// Stimulus pushes expected frames; a negedge monitor pops them on each bcd_valid pulse.
module tb_seven_seg_to_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  digit_en;
  logic [15:0] bcd_value;
  logic        bcd_valid;
  logic        frame_error;
  logic [3:0]  digit_err;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  e;
    logic        fe;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic prev_valid = 1'b0;

  seven_seg_to_bcd #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .digit_en(digit_en),
    .bcd_value(bcd_value), .bcd_valid(bcd_valid),
    .frame_error(frame_error), .digit_err(digit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] seg, input int n);
    digit_en = en;
    seg_in   = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic [3:0] e, input logic fe);
    exp_t x;
    x.v = v; x.e = e; x.fe = fe; x.cyc = cyc;
    q.push_back(x);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_value"}, 32'(bcd_value), 32'h0);
    chk({tag, "_valid"}, 32'(bcd_valid), 32'h0);
    chk({tag, "_ferr"},  32'(frame_error), 32'h0);
    chk({tag, "_derr"},  32'(digit_err), 32'h0);
  endtask

  always @(negedge clk) begin
    if (bcd_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(bcd_value), 32'hDEAD_BEEF);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("frame_value", 32'(bcd_value), 32'(x.v));
        chk("frame_derr",  32'(digit_err), 32'(x.e));
        chk("frame_ferr",  32'(frame_error), 32'(x.fe));
        chk("frame_cycle", 32'(cyc), 32'(x.cyc));
      end
      if (prev_valid) chk("valid_back_to_back", 32'(prev_valid), 32'h0);
    end
    prev_valid = bcd_valid;
  end

  initial begin
    reset = 1'b1; seg_in = '0; digit_en = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Basic scan 1,2,3,4
    drive(4'b0001, 7'h06, 3);
    drive(4'b0010, 7'h5B, 3);
    drive(4'b0100, 7'h4F, 3);
    drive(4'b1000, 7'h66, 3);
    expect_frame(16'h4321, 4'b0000, 1'b0);

    // Digit 1 too short, then replaced by 6
    drive(4'b0001, 7'h06, 3);
    drive(4'b0010, 7'h5B, 2);
    drive(4'b0010, 7'h7D, 3);
    drive(4'b0100, 7'h4F, 3);
    drive(4'b1000, 7'h66, 3);
    expect_frame(16'h4361, 4'b0000, 1'b0);

    // Invalid pattern on digit 2; error held until next clean frame
    drive(4'b0001, 7'h3F, 3);
    drive(4'b0010, 7'h06, 3);
    drive(4'b0100, 7'h49, 3);
    drive(4'b1000, 7'h4F, 3);
    expect_frame(16'h3F10, 4'b0100, 1'b1);
    drive(4'b0000, 7'h00, 5);
    chk("ferr_held", 32'(frame_error), 32'h1);
    chk("derr_held", 32'(digit_err), 32'h4);
    chk("value_held", 32'(bcd_value), 32'h3F10);
    drive(4'b0001, 7'h06, 3);
    drive(4'b0010, 7'h5B, 3);
    drive(4'b0100, 7'h4F, 3);
    drive(4'b1000, 7'h66, 3);
    expect_frame(16'h4321, 4'b0000, 1'b0);

    // Non-one-hot and blanking never accept; a long hold accepts once
    drive(4'b0011, 7'h7F, 10);
    drive(4'b0000, 7'h7F, 10);
    chk("no_accept_value", 32'(bcd_value), 32'h4321);
    drive(4'b0001, 7'h7F, 20);
    drive(4'b0010, 7'h06, 3);
    drive(4'b0100, 7'h5B, 3);
    drive(4'b1000, 7'h4F, 3);
    expect_frame(16'h3218, 4'b0000, 1'b0);

    // Reset mid-frame discards partial frame
    drive(4'b0001, 7'h3F, 3);
    drive(4'b0010, 7'h06, 3);
    drive(4'b0100, 7'h5B, 3);
    reset = 1'b1;
    drive(4'b0000, 7'h00, 1);
    reset = 1'b0;
    check_idle_outputs("midreset");
    drive(4'b1000, 7'h4F, 3);
    drive(4'b0000, 7'h00, 3);
    check_idle_outputs("partial");
    drive(4'b0001, 7'h3F, 3);
    drive(4'b0010, 7'h06, 3);
    chk("partial2_value", 32'(bcd_value), 32'h0);
    drive(4'b0100, 7'h5B, 3);
    expect_frame(16'h3210, 4'b0000, 1'b0);

    // Reset coinciding with the completing accept wins
    drive(4'b0001, 7'h06, 3);
    drive(4'b0010, 7'h06, 3);
    drive(4'b0100, 7'h06, 3);
    drive(4'b1000, 7'h06, 2);
    reset = 1'b1;
    drive(4'b1000, 7'h06, 1);
    reset = 1'b0;
    drive(4'b0000, 7'h00, 2);
    check_idle_outputs("reset_wins");

    // Out-of-order scan with invalid 08 on digit 2
    drive(4'b1000, 7'h67, 3);
    drive(4'b0010, 7'h07, 3);
    drive(4'b0001, 7'h3F, 3);
    drive(4'b0100, 7'h08, 3);
    expect_frame(16'h9F70, 4'b0100, 1'b1);

    drive(4'b0000, 7'h00, 5);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
